// File: rtl/iob_dmem_slave_if.sv
// IOB request/response bundle between the CPU bridge (master) and a memory slave.
interface iob_dmem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  iob_valid_i;
  logic [ADDR_W-1:0]     iob_addr_i;
  logic [DATA_W-1:0]     iob_wdata_i;
  logic [DATA_W/8-1:0]   iob_wstrb_i;
  logic                  iob_ready_o;
  logic [DATA_W-1:0]     iob_rdata_o;

  modport master (
    output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_ready_o, iob_rdata_o
  );

  modport slave (
    input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_ready_o, iob_rdata_o
  );
endinterface

// File: rtl/iob_dmem_slave.sv
// IOB data memory slave: byte-strobed word RAM with programmable wait states,
// a registered single-cycle ready pulse and a sticky out-of-range error flag.
module iob_dmem_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  iob_dmem_slave_if.slave       bus,
  output logic                  err_o,
  input  logic                  err_clr_i
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LimitAddr = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [7:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_access;
  logic                w_inRange;
  logic                w_isWrite;
  logic [IDX_W-1:0]    w_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (bus.iob_valid_i) w_nextState = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt == 8'd1)   w_nextState = S_ACCESS;
      S_ACCESS: w_nextState = S_RESP;
      S_RESP:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Decode uses the latched request, so a master dropping valid early cannot corrupt it.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && bus.iob_valid_i;
    w_access  = (r_state == S_ACCESS);
    w_isWrite = |r_wstrb;
    w_inRange = (r_addr >= BASE_ADDR) && ({1'b0, r_addr} < LimitAddr);
    w_idx     = IDX_W'((r_addr - BASE_ADDR) >> OFF_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 8'(WAIT_CYCLES);
        r_addr  <= bus.iob_addr_i;
        r_wdata <= bus.iob_wdata_i;
        r_wstrb <= bus.iob_wstrb_i;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      r_ready <= w_access;
      if (w_access) r_rdata <= (w_inRange && !w_isWrite) ? r_mem[w_idx] : '0;
      // A new error on the same edge as a clear must win.
      if (w_access && !w_inRange) r_err <= 1'b1;
      else if (err_clr_i)         r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && w_inRange && w_isWrite) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (r_wstrb[k]) r_mem[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
      end
    end
  end

  assign bus.iob_ready_o = r_ready;
  assign bus.iob_rdata_o = r_rdata;
  assign err_o           = r_err;
endmodule
